// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg -- shared types for the load/store unit.
//   lsu_size_e  : access size encoding as presented by the MEM stage.
//   lsu_state_e : LSU FSM state encoding (3 bits).
//   lsu_misaligned() : alignment/legality check for a request.
// Optional macro LSU_BYTE_STROBE_EN removes the read-modify-write states.
package mem_lsu_pkg;

    localparam int unsigned LSU_DATA_W = 32;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10,
        LSU_SIZE_X = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        LSU_IDLE   = 3'd0,
        LSU_LOAD   = 3'd1,
        LSU_WR     = 3'd2,
`ifndef LSU_BYTE_STROBE_EN
        LSU_RMW_RD = 3'd3,
        LSU_RMW_WR = 3'd4,
`endif
        LSU_RESP   = 3'd5
    } lsu_state_e;

    // Halfwords need addr[0]=0, words need addr[1:0]=00, size 11 is never legal.
    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            LSU_SIZE_B: lsu_misaligned = 1'b0;
            LSU_SIZE_H: lsu_misaligned = addr_lo[0];
            LSU_SIZE_W: lsu_misaligned = (addr_lo != 2'b00);
            default:    lsu_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align -- combinational lane steering for the load/store unit.
// Ports:
//   size, uns, addr_lo : latched request attributes
//   raw                : word read from the RAM (load path)
//   wdata              : right-aligned store data
//   old                : previously read word (RMW merge, absent with LSU_BYTE_STROBE_EN)
//   load_data          : selected lane, sign- or zero-extended
//   store_data         : word to write (merged, or lane-replicated with strobes)
//   be                 : per-byte write mask (only with LSU_BYTE_STROBE_EN)
module lsu_align
    import mem_lsu_pkg::*;
(
    input  lsu_size_e              size,
    input  logic                   uns,
    input  logic [1:0]             addr_lo,
    input  logic [LSU_DATA_W-1:0]  raw,
    input  logic [LSU_DATA_W-1:0]  wdata,
`ifndef LSU_BYTE_STROBE_EN
    input  logic [LSU_DATA_W-1:0]  old,
`endif
`ifdef LSU_BYTE_STROBE_EN
    output logic [3:0]             be,
`endif
    output logic [LSU_DATA_W-1:0]  load_data,
    output logic [LSU_DATA_W-1:0]  store_data
);

    logic [LSU_DATA_W-1:0] shifted;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [LSU_DATA_W-1:0] rep;
    logic [3:0]            be_m;

    always_comb begin
        shifted   = raw >> {addr_lo, 3'b000};
        byte_v    = shifted[7:0];
        half_v    = addr_lo[1] ? raw[31:16] : raw[15:0];
        load_data = '0;
        rep       = '0;
        be_m      = '0;
        case (size)
            LSU_SIZE_B: begin
                load_data = uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
                rep       = {4{wdata[7:0]}};
                be_m      = 4'b0001 << addr_lo;
            end
            LSU_SIZE_H: begin
                load_data = uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
                rep       = {2{wdata[15:0]}};
                be_m      = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            LSU_SIZE_W: begin
                load_data = raw;
                rep       = wdata;
                be_m      = 4'b1111;
            end
            default: ;
        endcase
    end

`ifdef LSU_BYTE_STROBE_EN
    // The RAM applies the mask, so every lane simply carries the replicated data.
    assign store_data = rep;
    assign be         = be_m;
`else
    always_comb begin
        store_data = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be_m[i]) store_data[8*i +: 8] = rep[8*i +: 8];
        end
    end
`endif

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu -- load/store initiator between the MEM stage and a word RAM.
// Request side : req_valid_i/req_ready_o handshake, we, size, unsigned, addr, wdata.
// Response side: rsp_valid_o one-cycle pulse with rsp_rdata_o and rsp_err_o.
// RAM side     : word-aligned ram_addr_o, ram_ren_o, ram_wen_o, ram_wdata_o,
//                combinational ram_rdata_i; ram_be_o with LSU_BYTE_STROBE_EN.
// Optional macro LSU_BYTE_STROBE_EN: sub-word stores use byte strobes instead of RMW.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_ren_o,
    output logic              ram_wen_o,
    output logic [DATA_W-1:0] ram_wdata_o,
`ifdef LSU_BYTE_STROBE_EN
    output logic [3:0]        ram_be_o,
`endif
    input  logic [DATA_W-1:0] ram_rdata_i
);

    lsu_state_e        state_q, state_d;
    logic              we_q, uns_q, err_q;
    lsu_size_e         size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [DATA_W-1:0] load_data, store_data;
    logic              accept, req_err;
`ifdef LSU_BYTE_STROBE_EN
    logic [3:0]        be;
`else
    logic [DATA_W-1:0] old_q;
`endif

    // Ready is purely a function of the state, so accept is derived from state_q directly.
    assign accept  = req_valid_i && (state_q == LSU_IDLE);
    assign req_err = lsu_misaligned(lsu_size_e'(req_size_i), req_addr_i[1:0]);

    lsu_align u_align (
        .size       (size_q),
        .uns        (uns_q),
        .addr_lo    (addr_q[1:0]),
        .raw        (ram_rdata_i),
        .wdata      (wdata_q),
`ifndef LSU_BYTE_STROBE_EN
        .old        (old_q),
`endif
`ifdef LSU_BYTE_STROBE_EN
        .be         (be),
`endif
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= LSU_SIZE_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifndef LSU_BYTE_STROBE_EN
            old_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                err_q   <= req_err;
                size_q  <= lsu_size_e'(req_size_i);
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                rdata_q <= '0;
            end
            if (state_q == LSU_LOAD) rdata_q <= load_data;
`ifndef LSU_BYTE_STROBE_EN
            if (state_q == LSU_RMW_RD) old_q <= ram_rdata_i;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_err_o   = 1'b0;
        rsp_rdata_o = '0;
        ram_ren_o   = 1'b0;
        ram_wen_o   = 1'b0;
        ram_wdata_o = '0;
        ram_addr_o  = '0;
`ifdef LSU_BYTE_STROBE_EN
        ram_be_o    = '0;
`endif
        case (state_q)
            LSU_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (req_err)                                state_d = LSU_RESP;
                    else if (!req_we_i)                         state_d = LSU_LOAD;
`ifdef LSU_BYTE_STROBE_EN
                    else                                        state_d = LSU_WR;
`else
                    else if (req_size_i == LSU_SIZE_W)          state_d = LSU_WR;
                    else                                        state_d = LSU_RMW_RD;
`endif
                end
            end
            LSU_LOAD: begin
                ram_ren_o = 1'b1;
                state_d   = LSU_RESP;
            end
            LSU_WR: begin
                ram_wen_o   = 1'b1;
                ram_wdata_o = store_data;
`ifdef LSU_BYTE_STROBE_EN
                ram_be_o    = be;
`endif
                state_d     = LSU_RESP;
            end
`ifndef LSU_BYTE_STROBE_EN
            LSU_RMW_RD: begin
                ram_ren_o = 1'b1;
                state_d   = LSU_RMW_WR;
            end
            LSU_RMW_WR: begin
                ram_wen_o   = 1'b1;
                ram_wdata_o = store_data;
                state_d     = LSU_RESP;
            end
`endif
            LSU_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
                rsp_rdata_o = (we_q || err_q) ? '0 : rdata_q;
                state_d     = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
        if (ram_ren_o || ram_wen_o) ram_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] ram_addr_o;
    logic        ram_ren_o;
    logic        ram_wen_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
`ifdef LSU_BYTE_STROBE_EN
    logic [3:0]  ram_be_o;
    localparam int SUB_LAT = 2;
`else
    localparam int SUB_LAT = 3;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .ram_addr_o(ram_addr_o), .ram_ren_o(ram_ren_o), .ram_wen_o(ram_wen_o),
        .ram_wdata_o(ram_wdata_o),
`ifdef LSU_BYTE_STROBE_EN
        .ram_be_o(ram_be_o),
`endif
        .ram_rdata_i(ram_rdata_i)
    );

    // Word RAM model: combinational read, write on the clock edge.
    assign ram_rdata_i = mem[ram_addr_o[9:2]];
    always @(posedge clk) begin
        if (ram_wen_o) begin
`ifdef LSU_BYTE_STROBE_EN
            for (int i = 0; i < 4; i++)
                if (ram_be_o[i]) mem[ram_addr_o[9:2]][8*i +: 8] = ram_wdata_o[8*i +: 8];
`else
            mem[ram_addr_o[9:2]] = ram_wdata_o;
`endif
        end
    end

    // Issue one request and watch it until its response (bounded to 10 cycles; lat=0 on timeout).
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nren, output int nwen, output logic [31:0] waddr,
                         output logic [31:0] wword, output logic [3:0] wbe);
        rdata = '0; err = 1'b0; lat = 0; nren = 0; nwen = 0;
        waddr = '0; wword = '0; wbe = '0;
        @(negedge clk);
        req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (ram_ren_o) nren++;
            if (ram_wen_o) begin
                nwen++;
                waddr = ram_addr_o;
                wword = ram_wdata_o;
`ifdef LSU_BYTE_STROBE_EN
                wbe = ram_be_o;
`else
                wbe = 4'b1111;
`endif
            end
            if (rsp_valid_o) begin
                lat = c; rdata = rsp_rdata_o; err = rsp_err_o;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++; if ({req_ready_o, rsp_valid_o, rsp_err_o, ram_ren_o, ram_wen_o} !== 5'b10000) begin
            miscompares++; $display("FAIL reset_ctrl: got %b want 10000", {req_ready_o, rsp_valid_o, rsp_err_o, ram_ren_o, ram_wen_o}); end
        vectors++; if ({rsp_rdata_o, ram_addr_o, ram_wdata_o} !== 96'h0) begin
            miscompares++; $display("FAIL reset_data: got %h want 0", {rsp_rdata_o, ram_addr_o, ram_wdata_o}); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd, wa, ww; logic er; int lat, nr, nw; logic [3:0] be;
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, rd, er, lat, nr, nw, wa, ww, be);
        vectors++; if ({lat, nr, nw} !== {32'd2, 32'd0, 32'd1}) begin
            miscompares++; $display("FAIL sw_timing: got lat=%0d ren=%0d wen=%0d want 2/0/1", lat, nr, nw); end
        vectors++; if ({wa, ww, be} !== {32'h100, 32'hDEADBEEF, 4'b1111}) begin
            miscompares++; $display("FAIL sw_write: got %h %h %b want 00000100 deadbeef 1111", wa, ww, be); end
        vectors++; if ({er, rd} !== 33'h0) begin
            miscompares++; $display("FAIL sw_rsp: got err=%b rdata=%h want 0/0", er, rd); end
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat, nr, nw, wa, ww, be);
        vectors++; if ({lat, nr, nw, er, rd} !== {32'd2, 32'd1, 32'd0, 1'b0, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL lw: got lat=%0d ren=%0d wen=%0d err=%b rdata=%h want 2/1/0/0/deadbeef", lat, nr, nw, er, rd); end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd, wa, ww; logic er; int lat, nr, nw; logic [3:0] be;
        logic [1:0]  sz [6]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
        logic        un [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [6]  = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h201, 32'h200};
        logic [31:0] ex [6]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0000007F, 32'h80FF7F01};
        mem[32'h200 >> 2] = 32'h80FF7F01;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, sz[i], un[i], ad[i], 32'h0, rd, er, lat, nr, nw, wa, ww, be);
            vectors++; if ({lat, er, rd} !== {32'd2, 1'b0, ex[i]}) begin
                miscompares++; $display("FAIL load_ext[%0d]: got lat=%0d err=%b rdata=%h want 2/0/%h", i, lat, er, rd, ex[i]); end
        end
    endtask

    task automatic test_rmw();
        logic [31:0] rd, wa, ww; logic er; int lat, nr, nw; logic [3:0] be;
        mem[32'h300 >> 2] = 32'h11223344;
        issue(1'b1, 2'b00, 1'b0, 32'h301, 32'h123456AA, rd, er, lat, nr, nw, wa, ww, be);
`ifdef LSU_BYTE_STROBE_EN
        vectors++; if ({nr, nw, ww, be} !== {32'd0, 32'd1, 32'hAAAAAAAA, 4'b0010}) begin
            miscompares++; $display("FAIL sb_write: got ren=%0d wen=%0d data=%h be=%b want 0/1/aaaaaaaa/0010", nr, nw, ww, be); end
`else
        vectors++; if ({nr, nw, ww} !== {32'd1, 32'd1, 32'h1122AA44}) begin
            miscompares++; $display("FAIL sb_write: got ren=%0d wen=%0d data=%h want 1/1/1122aa44", nr, nw, ww); end
`endif
        vectors++; if ({lat, wa, er} !== {SUB_LAT, 32'h300, 1'b0}) begin
            miscompares++; $display("FAIL sb_rsp: got lat=%0d addr=%h err=%b want %0d/00000300/0", lat, wa, er, SUB_LAT); end
        vectors++; if (mem[32'h300 >> 2] !== 32'h1122AA44) begin
            miscompares++; $display("FAIL sb_mem: got %h want 1122aa44", mem[32'h300 >> 2]); end
        issue(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000BEEF, rd, er, lat, nr, nw, wa, ww, be);
        vectors++; if ({lat, mem[32'h300 >> 2]} !== {SUB_LAT, 32'hBEEFAA44}) begin
            miscompares++; $display("FAIL sh_mem: got lat=%0d mem=%h want %0d/beefaa44", lat, mem[32'h300 >> 2], SUB_LAT); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, wa, ww; logic er; int lat, nr, nw; logic [3:0] be;
        issue(1'b0, 2'b10, 1'b0, 32'h402, 32'h0, rd, er, lat, nr, nw, wa, ww, be);
        vectors++; if ({lat, nr, nw, er, rd} !== {32'd1, 32'd0, 32'd0, 1'b1, 32'h0}) begin
            miscompares++; $display("FAIL lw_misalign: got lat=%0d ren=%0d wen=%0d err=%b rdata=%h want 1/0/0/1/0", lat, nr, nw, er, rd); end
        issue(1'b0, 2'b11, 1'b0, 32'h400, 32'h0, rd, er, lat, nr, nw, wa, ww, be);
        vectors++; if ({lat, nr, nw, er, rd} !== {32'd1, 32'd0, 32'd0, 1'b1, 32'h0}) begin
            miscompares++; $display("FAIL size11: got lat=%0d ren=%0d wen=%0d err=%b rdata=%h want 1/0/0/1/0", lat, nr, nw, er, rd); end
        issue(1'b1, 2'b01, 1'b0, 32'h301, 32'h5555, rd, er, lat, nr, nw, wa, ww, be);
        vectors++; if ({lat, nw, er, mem[32'h300 >> 2]} !== {32'd1, 32'd0, 1'b1, 32'hBEEFAA44}) begin
            miscompares++; $display("FAIL sh_misalign: got lat=%0d wen=%0d err=%b mem=%h want 1/0/1/beefaa44", lat, nw, er, mem[32'h300 >> 2]); end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] rd, wa, ww; logic er; int lat, nr, nw; logic [3:0] be;
        issue(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'hCAFEF00D, rd, er, lat, nr, nw, wa, ww, be);
        vectors++; if ({lat, er, wa} !== {32'd2, 1'b0, 32'hFFFFFFFC}) begin
            miscompares++; $display("FAIL wrap_store: got lat=%0d err=%b addr=%h want 2/0/fffffffc", lat, er, wa); end
        issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, rd, er, lat, nr, nw, wa, ww, be);
        vectors++; if ({er, rd} !== {1'b0, 32'hCAFEF00D}) begin
            miscompares++; $display("FAIL wrap_load: got err=%b rdata=%h want 0/cafef00d", er, rd); end
    endtask

    task automatic test_reset_mid_rmw();
        mem[32'h300 >> 2] = 32'h01020304;
        @(negedge clk);
        req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
        req_addr_i = 32'h300; req_wdata_i = 32'hEE; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        #2;
`ifdef LSU_BYTE_STROBE_EN
        vectors++; if ({ram_ren_o, ram_wen_o} !== 2'b01) begin
            miscompares++; $display("FAIL pre_reset_strobe: got %b want 01", {ram_ren_o, ram_wen_o}); end
`else
        vectors++; if ({ram_ren_o, ram_wen_o} !== 2'b10) begin
            miscompares++; $display("FAIL pre_reset_strobe: got %b want 10", {ram_ren_o, ram_wen_o}); end
`endif
        rst = 1'b1;
        #1;
        vectors++; if ({ram_ren_o, ram_wen_o} !== 2'b00) begin
            miscompares++; $display("FAIL reset_drop: got %b want 00", {ram_ren_o, ram_wen_o}); end
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        vectors++; if ({req_ready_o, rsp_valid_o, mem[32'h300 >> 2]} !== {2'b10, 32'h01020304}) begin
            miscompares++; $display("FAIL reset_recover: got ready=%b valid=%b mem=%h want 1/0/01020304", req_ready_o, rsp_valid_o, mem[32'h300 >> 2]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] adr [3] = '{32'h204, 32'h208, 32'h20C};
        logic [31:0] exp_d [3] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3};
        logic [31:0] got [3] = '{32'h0, 32'h0, 32'h0};
        int idx = 0, pulses = 0, wide = 0, bad_ready = 0;
        logic prev = 1'b0, acc;
        for (int i = 0; i < 3; i++) mem[adr[i][9:2]] = exp_d[i];
        @(negedge clk);
        req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
        req_addr_i = adr[0]; req_valid_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c != 0) @(negedge clk);
            if (rsp_valid_o) begin
                if (pulses < 3) got[pulses] = rsp_rdata_o;
                pulses++;
                if (prev) wide++;
            end
            prev = rsp_valid_o;
            if ((ram_ren_o || rsp_valid_o) && req_ready_o) bad_ready++;
            acc = req_valid_i && req_ready_o;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx >= 3) req_valid_i = 1'b0;
                else req_addr_i = adr[idx];
            end
        end
        vectors++; if ({pulses, wide, bad_ready} !== {32'd3, 32'd0, 32'd0}) begin
            miscompares++; $display("FAIL b2b_pulses: got pulses=%0d wide=%0d ready_hi=%0d want 3/0/0", pulses, wide, bad_ready); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (got[i] !== exp_d[i]) begin
                miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got[i], exp_d[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_word_store_load();
        test_load_ext();
        test_rmw();
        test_misaligned();
        test_addr_wrap();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
